// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: types and constants shared by the blocks that talk to the
// nes_bus.
//   spr_state_e  : states of the OAM DMA initiator
//   ADDR_OAMDMA  : $4014, the register write that starts a sprite DMA
//   ADDR_OAMDATA : $2004, the PPU OAM data port that receives each byte
package nes_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN2,
      ALIGN,
      READ,
      WRITE
   } spr_state_e;

   localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
   localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage : nes_bus_pkg

// File: rtl/spr_dma_ctrl.sv
// spr_dma_ctrl: OAM (sprite) DMA initiator for the $4014 register.
// A CPU write of page P to REG_ADDR copies CPU $P00-$PFF into PPU OAM as
// XFER_LEN read/write pairs, the writes going to OAM_PORT. The block drives
// the nes_bus spr_* requester port and only advances on granted cycles, so
// a DMC steal simply replays the current access.
//
// Ports:
//   i_clk        CPU clock
//   i_rstn       asynchronous active-low reset
//   i_bus_addr   snooped bus address
//   i_bus_wdata  snooped bus write data (page number on a trigger)
//   i_bus_wn     snooped bus r_wn, 0 = write
//   o_spr_req    bus request, held for the whole transfer
//   i_spr_gnt    grant from the nes_bus arbiter
//   o_spr_addr   address driven while granted
//   o_spr_wn     1 = read, 0 = write
//   o_spr_wdata  write data for OAM_PORT
//   i_spr_rdata  read data, valid in the same cycle as a granted read
//   o_busy       high from trigger until the final write completes
module spr_dma_ctrl
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] REG_ADDR = ADDR_OAMDMA,
   parameter logic [15:0] OAM_PORT = ADDR_OAMDATA,
   parameter int unsigned XFER_LEN = 256
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [15:0] i_bus_addr,
   input  logic [7:0]  i_bus_wdata,
   input  logic        i_bus_wn,
   output logic        o_spr_req,
   input  logic        i_spr_gnt,
   output logic [15:0] o_spr_addr,
   output logic        o_spr_wn,
   output logic [7:0]  o_spr_wdata,
   input  logic [7:0]  i_spr_rdata,
   output logic        o_busy
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   spr_state_e  state_q;
   logic [7:0]  idx_q;
   logic [7:0]  page_q;
   logic        parity_q;
   logic        req_q;
   logic        busy_q;
   logic [15:0] addr_q;
   logic        wn_q;
   logic [7:0]  wdata_q;
   logic        trig;

   assign trig = (i_bus_addr == REG_ADDR) && !i_bus_wn;

   // The fetched byte is latched straight into the write-data register;
   // it is only ever consumed by the following WRITE, so no separate
   // data register is kept.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         page_q   <= '0;
         parity_q <= 1'b0;
         req_q    <= 1'b0;
         busy_q   <= 1'b0;
         addr_q   <= '0;
         wn_q     <= 1'b1;
         wdata_q  <= '0;
      end else begin
         parity_q <= ~parity_q;
         case (state_q)
            IDLE: begin
               if (trig) begin
                  page_q  <= i_bus_wdata;
                  idx_q   <= '0;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  addr_q  <= REG_ADDR;
                  wn_q    <= 1'b1;
                  // Odd-cycle trigger burns one extra granted cycle.
                  state_q <= parity_q ? ALIGN2 : ALIGN;
               end
            end
            ALIGN2: begin
               if (i_spr_gnt) state_q <= ALIGN;
            end
            ALIGN: begin
               if (i_spr_gnt) begin
                  addr_q  <= {page_q, idx_q};
                  wn_q    <= 1'b1;
                  state_q <= READ;
               end
            end
            READ: begin
               if (i_spr_gnt) begin
                  wdata_q <= i_spr_rdata;
                  addr_q  <= OAM_PORT;
                  wn_q    <= 1'b0;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               if (i_spr_gnt) begin
                  if (idx_q == LAST_IDX) begin
                     req_q   <= 1'b0;
                     busy_q  <= 1'b0;
                     addr_q  <= '0;
                     wn_q    <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     // 8-bit idx concatenated under the page: never
                     // crosses into the next page.
                     idx_q   <= idx_q + 8'd1;
                     addr_q  <= {page_q, idx_q + 8'd1};
                     wn_q    <= 1'b1;
                     state_q <= READ;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_spr_req   = req_q;
   assign o_busy      = busy_q;
   assign o_spr_addr  = addr_q;
   assign o_spr_wn    = wn_q;
   assign o_spr_wdata = wdata_q;

endmodule : spr_dma_ctrl

// File: tb/tb_spr_dma_ctrl.sv
// Bench for spr_dma_ctrl: a 64 KiB CPU memory answers granted reads, a
// per-cycle driver controls grant and snoops every granted access, and the
// expected access stream is built from the transfer rules (lead cycles,
// then read {page,i} / write $2004 of mem[{page,i}] for i = 0..255).
module tb_spr_dma_ctrl;

   typedef struct {
      logic [15:0] a;
      logic        wn;
      logic [7:0]  d;
      bit          ca;
      bit          cd;
   } acc_t;

   logic        clk;
   logic        rstn;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_wn;
   logic        gnt;
   logic        req;
   logic [15:0] spr_addr;
   logic        spr_wn;
   logic [7:0]  spr_wdata;
   logic [7:0]  spr_rdata;
   logic        busy;

   logic [7:0]  mem [65536];
   acc_t        log_q[$];
   acc_t        exp_q[$];
   int          cyc;
   int          errors;
   int          checks;

   spr_dma_ctrl #(
      .REG_ADDR (16'h4014),
      .OAM_PORT (16'h2004),
      .XFER_LEN (256)
   ) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_bus_addr  (bus_addr),
      .i_bus_wdata (bus_wdata),
      .i_bus_wn    (bus_wn),
      .o_spr_req   (req),
      .i_spr_gnt   (gnt),
      .o_spr_addr  (spr_addr),
      .o_spr_wn    (spr_wn),
      .o_spr_wdata (spr_wdata),
      .i_spr_rdata (spr_rdata),
      .o_busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign spr_rdata = mem[spr_addr];

   // Cycle counter since reset release; its LSB is the expected parity.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Reference access stream for one complete transfer.
   task automatic build_exp(input logic [7:0] page, input bit odd);
      acc_t e;
      exp_q.delete();
      if (odd) begin
         e = '{a: 16'h0000, wn: 1'b1, d: 8'h00, ca: 1'b0, cd: 1'b0};
         exp_q.push_back(e);
      end
      e = '{a: 16'h4014, wn: 1'b1, d: 8'h00, ca: 1'b1, cd: 1'b0};
      exp_q.push_back(e);
      for (int i = 0; i < 256; i++) begin
         e = '{a: {page, 8'(i)}, wn: 1'b1, d: 8'h00, ca: 1'b1, cd: 1'b0};
         exp_q.push_back(e);
         e = '{a: 16'h2004, wn: 1'b0, d: mem[{page, 8'(i)}], ca: 1'b1, cd: 1'b1};
         exp_q.push_back(e);
      end
   endtask

   // Triggers a transfer with the requested parity, then runs it cycle by
   // cycle. Grant is dropped for gap_a cycles once at granted count at_a,
   // likewise gap_b at at_b; rnd gives random grant. retrig_g re-writes
   // $4014 at that granted count; rst_g asserts reset there and returns.
   task automatic run_xfer(input logic [7:0] page, input bit odd,
                           input int at_a, input int gap_a,
                           input int at_b, input int gap_b,
                           input int retrig_g, input int rst_g, input bit rnd,
                           output int granted, output int wall,
                           output int stalls, output int freeze_err,
                           output bit timeout, output logic end_req);
      int          g;
      int          gap;
      bit          a_done;
      bit          b_done;
      bit          rt_done;
      bit          done;
      bit          prev_stall;
      logic [15:0] p_addr;
      logic        p_wn;
      logic [7:0]  p_wdata;
      acc_t        e;
      g = 0; gap = 0; a_done = 0; b_done = 0; rt_done = 0; done = 0;
      prev_stall = 0; p_addr = '0; p_wn = 1'b1; p_wdata = '0;
      wall = 0; stalls = 0; freeze_err = 0; timeout = 0;
      log_q.delete();
      @(negedge clk);
      while (cyc[0] != odd) @(negedge clk);
      gnt       = 1'b1;
      bus_addr  = 16'h4014;
      bus_wn    = 1'b0;
      bus_wdata = page;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         bus_addr  = 16'h0000;
         bus_wn    = 1'b1;
         bus_wdata = 8'h00;
         if (!busy) begin
            done = 1;
            break;
         end
         if (rst_g >= 0 && g == rst_g) begin
            rstn = 1'b0;
            #1;
            done = 1;
            break;
         end
         if (prev_stall && (spr_addr !== p_addr || spr_wn !== p_wn || spr_wdata !== p_wdata))
            freeze_err++;
         if (!a_done && g == at_a) begin a_done = 1; gap = gap_a; end
         if (!b_done && g == at_b) begin b_done = 1; gap = gap_b; end
         if (gap > 0) begin
            gnt = 1'b0;
            gap--;
         end else begin
            gnt = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (!rt_done && g == retrig_g) begin
            rt_done   = 1;
            bus_addr  = 16'h4014;
            bus_wn    = 1'b0;
            bus_wdata = page ^ 8'h55;
         end
         wall++;
         if (req && gnt) begin
            e = '{a: spr_addr, wn: spr_wn, d: spr_wdata, ca: 1'b1, cd: 1'b1};
            log_q.push_back(e);
            g++;
         end
         if (req && !gnt) stalls++;
         prev_stall = req && !gnt;
         p_addr = spr_addr; p_wn = spr_wn; p_wdata = spr_wdata;
      end
      gnt     = 1'b1;
      timeout = !done;
      granted = g;
      end_req = req;
   endtask

   task automatic test_reset();
      rstn = 1'b0; gnt = 1'b0;
      bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if ({req, busy, spr_addr, spr_wn, spr_wdata} !== {1'b0, 1'b0, 16'h0000, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL reset_values: req=%b busy=%b addr=%h wn=%b wdata=%h, required 0 0 0000 1 00",
                  req, busy, spr_addr, spr_wn, spr_wdata);
      end
      rstn = 1'b1;
      gnt  = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL grant_without_req: req=%b busy=%b, required 0 0", req, busy);
      end
   endtask

   task automatic test_even();
      int gr, wl, st, fz; bit to; logic er;
      run_xfer(8'h02, 1'b0, -1, 0, -1, 0, -1, -1, 1'b0, gr, wl, st, fz, to, er);
      build_exp(8'h02, 1'b0);
      checks++;
      if (to || gr != 513 || wl != 513) begin
         errors++;
         $display("FAIL even_len: timeout=%0d granted=%0d busy_cycles=%0d, required 0 513 513", to, gr, wl);
      end
      checks++;
      if (busy !== 1'b0 || er !== 1'b0) begin
         errors++;
         $display("FAIL even_end: busy=%b req=%b, required 0 0", busy, er);
      end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL even_count: accesses=%0d, required %0d", log_q.size(), exp_q.size());
      end
      for (int k = 0; k < log_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (log_q[k].wn !== exp_q[k].wn || (exp_q[k].ca && log_q[k].a !== exp_q[k].a) ||
             (exp_q[k].cd && log_q[k].d !== exp_q[k].d)) begin
            errors++;
            $display("FAIL even_seq[%0d]: got a=%h wn=%b d=%h, required a=%h wn=%b d=%h",
                     k, log_q[k].a, log_q[k].wn, log_q[k].d, exp_q[k].a, exp_q[k].wn, exp_q[k].d);
         end
      end
   endtask

   task automatic test_odd();
      int gr, wl, st, fz; bit to; logic er; int first_rd;
      run_xfer(8'h02, 1'b1, -1, 0, -1, 0, -1, -1, 1'b0, gr, wl, st, fz, to, er);
      build_exp(8'h02, 1'b1);
      first_rd = -1;
      foreach (log_q[k]) if (first_rd < 0 && log_q[k].a == 16'h0200) first_rd = k;
      checks++;
      if (to || gr != 514 || er !== 1'b0) begin
         errors++;
         $display("FAIL odd_len: timeout=%0d granted=%0d req=%b, required 0 514 0", to, gr, er);
      end
      checks++;
      if (first_rd != 2) begin
         errors++;
         $display("FAIL odd_first_read: index=%0d, required 2", first_rd);
      end
      for (int k = 0; k < log_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (log_q[k].wn !== exp_q[k].wn || (exp_q[k].ca && log_q[k].a !== exp_q[k].a) ||
             (exp_q[k].cd && log_q[k].d !== exp_q[k].d)) begin
            errors++;
            $display("FAIL odd_seq[%0d]: got a=%h wn=%b d=%h, required a=%h wn=%b d=%h",
                     k, log_q[k].a, log_q[k].wn, log_q[k].d, exp_q[k].a, exp_q[k].wn, exp_q[k].d);
         end
      end
   endtask

   task automatic test_stalls();
      int gr, wl, st, fz; bit to; logic er;
      // READ idx $10 is granted access 1+2*16, WRITE idx $80 is 2+2*128.
      run_xfer(8'h02, 1'b0, 33, 3, 258, 2, -1, -1, 1'b0, gr, wl, st, fz, to, er);
      build_exp(8'h02, 1'b0);
      checks++;
      if (to || gr != 513 || wl != 518 || fz != 0) begin
         errors++;
         $display("FAIL stall_len: timeout=%0d granted=%0d busy_cycles=%0d freeze_err=%0d, required 0 513 518 0",
                  to, gr, wl, fz);
      end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL stall_count: accesses=%0d, required %0d", log_q.size(), exp_q.size());
      end
      for (int k = 0; k < log_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (log_q[k].wn !== exp_q[k].wn || (exp_q[k].ca && log_q[k].a !== exp_q[k].a) ||
             (exp_q[k].cd && log_q[k].d !== exp_q[k].d)) begin
            errors++;
            $display("FAIL stall_seq[%0d]: got a=%h wn=%b d=%h, required a=%h wn=%b d=%h",
                     k, log_q[k].a, log_q[k].wn, log_q[k].d, exp_q[k].a, exp_q[k].wn, exp_q[k].d);
         end
      end
   endtask

   task automatic test_page_ff();
      int gr, wl, st, fz; bit to; logic er; int zero_hits; int writes; logic [15:0] last_rd;
      run_xfer(8'hFF, 1'b0, -1, 0, -1, 0, -1, -1, 1'b0, gr, wl, st, fz, to, er);
      build_exp(8'hFF, 1'b0);
      zero_hits = 0; writes = 0; last_rd = 16'h0000;
      foreach (log_q[k]) begin
         if (log_q[k].a == 16'h0000) zero_hits++;
         if (log_q[k].wn == 1'b0) writes++;
         else last_rd = log_q[k].a;
      end
      checks++;
      if (to || zero_hits != 0 || writes != 256 || last_rd !== 16'hFFFF) begin
         errors++;
         $display("FAIL page_ff: timeout=%0d zero_hits=%0d writes=%0d last_read=%h, required 0 0 256 ffff",
                  to, zero_hits, writes, last_rd);
      end
      for (int k = 0; k < log_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (log_q[k].wn !== exp_q[k].wn || (exp_q[k].ca && log_q[k].a !== exp_q[k].a) ||
             (exp_q[k].cd && log_q[k].d !== exp_q[k].d)) begin
            errors++;
            $display("FAIL page_ff_seq[%0d]: got a=%h wn=%b d=%h, required a=%h wn=%b d=%h",
                     k, log_q[k].a, log_q[k].wn, log_q[k].d, exp_q[k].a, exp_q[k].wn, exp_q[k].d);
         end
      end
   endtask

   task automatic test_retrigger();
      int gr, wl, st, fz; bit to; logic er;
      // $4014 rewritten during READ idx $40 (granted access 1+2*64).
      run_xfer(8'h05, 1'b0, -1, 0, -1, 0, 129, -1, 1'b0, gr, wl, st, fz, to, er);
      build_exp(8'h05, 1'b0);
      checks++;
      if (to || gr != 513 || log_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL retrig_len: timeout=%0d granted=%0d accesses=%0d, required 0 513 %0d",
                  to, gr, log_q.size(), exp_q.size());
      end
      for (int k = 0; k < log_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (log_q[k].wn !== exp_q[k].wn || (exp_q[k].ca && log_q[k].a !== exp_q[k].a) ||
             (exp_q[k].cd && log_q[k].d !== exp_q[k].d)) begin
            errors++;
            $display("FAIL retrig_seq[%0d]: got a=%h wn=%b d=%h, required a=%h wn=%b d=%h",
                     k, log_q[k].a, log_q[k].wn, log_q[k].d, exp_q[k].a, exp_q[k].wn, exp_q[k].d);
         end
      end
   endtask

   task automatic test_reset_mid();
      int gr, wl, st, fz; bit to; logic er;
      // WRITE idx $90 is granted access 2+2*144.
      run_xfer(8'h02, 1'b0, -1, 0, -1, 0, -1, 290, 1'b0, gr, wl, st, fz, to, er);
      checks++;
      if (to || {req, busy, spr_addr, spr_wn, spr_wdata} !== {1'b0, 1'b0, 16'h0000, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL reset_mid: timeout=%0d req=%b busy=%b addr=%h wn=%b wdata=%h, required 0 0 0 0000 1 00",
                  to, req, busy, spr_addr, spr_wn, spr_wdata);
      end
      @(negedge clk);
      rstn = 1'b1;
      run_xfer(8'h03, 1'b0, -1, 0, -1, 0, -1, -1, 1'b0, gr, wl, st, fz, to, er);
      build_exp(8'h03, 1'b0);
      checks++;
      if (to || gr != 513 || log_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL restart_len: timeout=%0d granted=%0d accesses=%0d, required 0 513 %0d",
                  to, gr, log_q.size(), exp_q.size());
      end
      for (int k = 0; k < log_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (log_q[k].wn !== exp_q[k].wn || (exp_q[k].ca && log_q[k].a !== exp_q[k].a) ||
             (exp_q[k].cd && log_q[k].d !== exp_q[k].d)) begin
            errors++;
            $display("FAIL restart_seq[%0d]: got a=%h wn=%b d=%h, required a=%h wn=%b d=%h",
                     k, log_q[k].a, log_q[k].wn, log_q[k].d, exp_q[k].a, exp_q[k].wn, exp_q[k].d);
         end
      end
   endtask

   task automatic test_random();
      int gr, wl, st, fz; bit to; logic er; logic [7:0] page; bit odd; int lead;
      for (int it = 0; it < 3; it++) begin
         page = 8'($urandom_range(0, 255));
         odd  = 1'($urandom_range(0, 1));
         lead = odd ? 2 : 1;
         run_xfer(page, odd, -1, 0, -1, 0, -1, -1, 1'b1, gr, wl, st, fz, to, er);
         build_exp(page, odd);
         checks++;
         if (to || gr != lead + 512 || wl != lead + 512 + st || fz != 0 || er !== 1'b0) begin
            errors++;
            $display("FAIL rand_len[%0d]: timeout=%0d granted=%0d busy_cycles=%0d stalls=%0d freeze_err=%0d req=%b, required granted=%0d",
                     it, to, gr, wl, st, fz, er, lead + 512);
         end
         for (int k = 0; k < log_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (log_q[k].wn !== exp_q[k].wn || (exp_q[k].ca && log_q[k].a !== exp_q[k].a) ||
                (exp_q[k].cd && log_q[k].d !== exp_q[k].d)) begin
               errors++;
               $display("FAIL rand_seq[%0d][%0d]: got a=%h wn=%b d=%h, required a=%h wn=%b d=%h",
                        it, k, log_q[k].a, log_q[k].wn, log_q[k].d, exp_q[k].a, exp_q[k].wn, exp_q[k].d);
            end
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      test_reset();
      test_even();
      test_odd();
      test_stalls();
      test_page_ff();
      test_retrigger();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_spr_dma_ctrl
